program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of one program word.
REQ-002 Parameter DEPTH, default 32, SHALL set the maximum program words; ADDR_W = log2(DEPTH) = 5.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-low; all registers clear when reset=0 at a rising edge.
REQ-005 start  input  1  SHALL request a load; sampled only in IDLE.
REQ-006 len_in  input  ADDR_W+1  SHALL give the program length in words; it is latched on an accepted start.
REQ-007 host_valid / host_data[DATA_W] / host_ready  (in/in/out) SHALL form the host byte handshake; a transfer occurs when host_valid=1 and host_ready=1 at the same edge.
REQ-008 chk_in  input  DATA_W  SHALL give the expected image checksum, sampled on an accepted start.
REQ-009 Load  output  1  SHALL drive the CPU Load input.
REQ-010 data_out  output  DATA_W  SHALL drive the CPU data_in input.
REQ-011 busy / done / err  output  1 each  SHALL give status: busy outside IDLE, done as a one-cycle completion pulse, err as the checksum failure flag.

Function
REQ-012 The FSM SHALL have the states IDLE, FILL, CHECK, STREAM and DONE.
REQ-013 IDLE->FILL SHALL occur on start=1; len_in>DEPTH saturates to DEPTH; len_in=0 goes IDLE->DONE, and Load is never asserted.
REQ-014 In FILL, host_ready SHALL be 1; each transfer writes buffer[wr_idx] and increments wr_idx from 0.
REQ-015 On the transfer of word len-1, FILL SHALL go to CHECK when PROGRAM_LOADER_CHECKSUM_EN is defined, else to STREAM.
REQ-016 In CHECK, a match SHALL go to STREAM; a mismatch SHALL set err=1 and go to DONE without streaming.
REQ-017 Load and data_out SHALL be registered outputs.
REQ-018 Load SHALL be high for exactly len consecutive cycles, with data_out=buffer[0..len-1] in order, one word per cycle.
REQ-019 The first Load=1 cycle SHALL begin one cycle after STREAM is entered.
REQ-020 When Load=0, data_out SHALL be 0.
REQ-021 After the last streamed word, the block SHALL enter DONE; done=1 for exactly one cycle; the next state is IDLE.
REQ-022 err SHALL stay set until the next accepted start.
REQ-023 start outside IDLE SHALL be ignored, and host transfers outside FILL SHALL not occur.
REQ-024 The wr_idx and rd_idx counters SHALL never wrap within a load; they clear on entry to FILL and STREAM respectively.

Reset
REQ-025 On reset, the block SHALL enter IDLE with Load=0, data_out=0, busy=0, done=0, err=0, host_ready=0 and both indices at 0.
REQ-026 Reset mid-FILL or mid-STREAM SHALL abort the load, with Load low from the next edge.
REQ-027 Buffer contents SHALL not be required to clear on reset.

Configuration
REQ-028 Macro PROGRAM_LOADER_CHECKSUM_EN defined: an 8-bit modulo-256 sum of accepted bytes SHALL be computed during FILL and compared in CHECK.
REQ-029 Macro PROGRAM_LOADER_CHECKSUM_EN undefined: there SHALL be no CHECK state and no sum register; chk_in is ignored and err is tied to 0.

Structure
REQ-030 Package loader_pkg SHALL hold DATA_W, DEPTH, ADDR_W and the FSM state typedef.
REQ-031 Sub-module loader_buffer SHALL be a DEPTH x DATA_W register array with synchronous write and combinational read; the FSM and counters stay in program_loader.

Verification
REQ-032 start, len_in=3, bytes 0x21,0x42,0x63 (macro off) -> Load high 3 cycles, data_out 0x21,0x42,0x63, then one done pulse.
REQ-033 len_in=40, 32 bytes -> exactly 32 transfers accepted, Load high 32 cycles.
REQ-034 Macro on, bytes 0x10,0x20, chk_in=0x30 -> streams 2 words; chk_in=0x31 -> err=1, Load never high, done pulse.
REQ-035 len_in=0 -> done pulse 1 cycle after start, host_ready never 1, Load never 1.
REQ-036 reset=0 during the 2nd streamed word of 4 -> Load=0 and busy=0 from the next edge; then start, len 1, byte 0x7F -> a clean 1-word stream of 0x7F.
REQ-037 host_valid toggling 1/0 each cycle during FILL -> the buffer order is preserved, and the stream matches the sent bytes.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared sizing and FSM encoding for the program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state to the encoding.
package loader_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_STREAM,
        S_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_e;
`endif

endpackage

// File: rtl/program_loader_if.sv
// Host byte handshake into the program loader.
// The loader is the slave; the host drives valid/data.
interface program_loader_if #(
    parameter int DATA_W = loader_pkg::DATA_W
) ();

    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;

    modport master (
        output host_valid,
        output host_data,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        output host_ready
    );

endinterface

// File: rtl/loader_buffer.sv
// Program image store: synchronous write, combinational read.
// Contents are not cleared by reset.
module loader_buffer #(
    parameter int DATA_W = loader_pkg::DATA_W,
    parameter int DEPTH  = loader_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Buffers a host program image, then streams it to the CPU Load port.
// Define PROGRAM_LOADER_CHECKSUM_EN to verify a byte checksum first.
module program_loader #(
    parameter int DATA_W = loader_pkg::DATA_W,
    parameter int DEPTH  = loader_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len_in,
    input  logic [DATA_W-1:0] chk_in,
    program_loader_if.slave   host,
    output logic              Load,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import loader_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] buf_rdata;
    logic              xfer;
    logic              last_wr;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic              err_q, err_d;
`else
    logic              unused_chk;
    assign unused_chk = ^chk_in;
`endif

    assign host.host_ready = (state_q == S_FILL);
    assign xfer    = host.host_valid && host.host_ready;
    assign last_wr = ({1'b0, wr_idx_q} == len_q - 1'b1);

    loader_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clock   (clock),
        .we_i    (xfer),
        .waddr_i (wr_idx_q),
        .wdata_i (host.host_data),
        .raddr_i (rd_idx_q[ADDR_W-1:0]),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        load_d   = 1'b0;
        dout_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        chk_d    = chk_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = (len_in > DEPTH_L) ? DEPTH_L : len_in;
                    wr_idx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d    = '0;
                    chk_d    = chk_in;
                    err_d    = 1'b0;
`endif
                    state_d  = (len_in == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + host.host_data;
`endif
                    // Hold the index on the last word so it never wraps.
                    if (last_wr) begin
                        rd_idx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d  = S_CHECK;
`else
                        state_d  = S_STREAM;
`endif
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (sum_q == chk_q) begin
                    rd_idx_d = '0;
                    state_d  = S_STREAM;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_STREAM: begin
                if (rd_idx_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    load_d   = 1'b1;
                    dout_d   = buf_rdata;
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            load_q   <= 1'b0;
            dout_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
            chk_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            load_q   <= load_d;
            dout_q   <= dout_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
            chk_q    <= chk_d;
            err_q    <= err_d;
`endif
        end
    end

    assign Load     = load_q;
    assign data_out = dout_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader.
// Checksum vectors run only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] len_in = '0;
    logic [7:0] chk_in = '0;
    logic       Load;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       err;

    program_loader_if #(.DATA_W(8)) host ();

    program_loader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .len_in   (len_in),
        .chk_in   (chk_in),
        .host     (host),
        .Load     (Load),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int         cyc = 0;
    int         ld_n = 0;
    int         done_n = 0;
    int         done_cyc = 0;
    int         rdy_n = 0;
    int         dz_bad = 0;
    logic [7:0] ld_data [256];
    int         ld_cyc [256];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (Load) begin
            if (ld_n < 256) begin
                ld_data[ld_n] = data_out;
                ld_cyc[ld_n]  = cyc;
            end
            ld_n++;
        end else if (data_out != 8'h00) begin
            dz_bad++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (host.host_ready) rdy_n++;
    end

    int xfers, start_cyc, b_ld, b_done, b_rdy, b_dz;

    task automatic start_load(input int len, input logic [7:0] ck);
        @(negedge clock);
        start  = 1'b1;
        len_in = 6'(len);
        chk_in = ck;
        @(posedge clock);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        b_ld      = ld_n;
        b_done    = done_n;
        b_rdy     = rdy_n;
        b_dz      = dz_bad;
        xfers     = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int n, input logic [7:0] base,
                        input logic [7:0] step, input bit tog);
        int idx = 0;
        bit acc;
        for (int c = 0; c < 2 * n + 8 && idx < n; c++) begin
            @(negedge clock);
            host.host_valid = !(tog && c[0]);
            host.host_data  = 8'(base + step * 8'(idx));
            acc = host.host_valid && host.host_ready;
            @(posedge clock);
            if (acc) idx++;
        end
        @(negedge clock);
        host.host_valid = 1'b0;
        host.host_data  = '0;
        xfers = idx;
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (done_n == b_done && c < 300) begin
            @(negedge clock);
            #1;
            c++;
        end
        chk($sformatf("%s_done_seen", nm), int'(done_n != b_done), 1);
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic check_stream(input string nm, input int exp,
                                input logic [7:0] base, input logic [7:0] step);
        int got = ld_n - b_ld;
        chk($sformatf("%s_load_count", nm), got, exp);
        if (exp > 0) begin
            chk($sformatf("%s_xfers", nm), xfers, exp);
            if (got > 0 && ld_n <= 256) begin
                chk($sformatf("%s_load_contig", nm),
                    ld_cyc[ld_n - 1] - ld_cyc[b_ld], got - 1);
                chk($sformatf("%s_done_after_load", nm),
                    done_cyc, ld_cyc[ld_n - 1] + 1);
                for (int i = 0; i < got && i < exp; i++) begin
                    chk($sformatf("%s_word%0d", nm, i),
                        ld_data[b_ld + i], 8'(base + step * 8'(i)));
                end
            end
        end else begin
            chk($sformatf("%s_done_latency", nm), done_cyc - start_cyc, 0);
            chk($sformatf("%s_ready_never", nm), rdy_n - b_rdy, 0);
        end
        chk($sformatf("%s_done_once", nm), done_n - b_done, 1);
        chk($sformatf("%s_data_zero", nm), dz_bad - b_dz, 0);
        chk($sformatf("%s_err", nm), err, 0);
        chk($sformatf("%s_busy_end", nm), busy, 0);
    endtask

    task automatic run(input string nm, input int len, input int n,
                       input logic [7:0] base, input logic [7:0] step,
                       input bit tog, input int exp);
        logic [7:0] ck = '0;
        for (int i = 0; i < exp; i++) ck = 8'(ck + base + step * 8'(i));
        start_load(len, ck);
        if (n > 0) feed(n, base, step, tog);
        wait_done(nm);
        check_stream(nm, exp, base, step);
    endtask

    typedef struct {
        int         len;
        int         n;
        logic [7:0] base;
        logic [7:0] step;
        bit         tog;
        int         exp;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        host.host_valid = 1'b0;
        host.host_data  = '0;

        vecs[0] = '{len: 3,  n: 3,  base: 8'h21, step: 8'h21, tog: 1'b0, exp: 3};
        vecs[1] = '{len: 40, n: 40, base: 8'h01, step: 8'h01, tog: 1'b0, exp: 32};
        vecs[2] = '{len: 5,  n: 5,  base: 8'hA0, step: 8'h11, tog: 1'b1, exp: 5};
        vecs[3] = '{len: 0,  n: 0,  base: 8'h00, step: 8'h00, tog: 1'b0, exp: 0};
        vecs[4] = '{len: 1,  n: 1,  base: 8'hFF, step: 8'h00, tog: 1'b0, exp: 1};
        vecs[5] = '{len: 32, n: 32, base: 8'h80, step: 8'h03, tog: 1'b1, exp: 32};

        repeat (3) @(negedge clock);
        chk("rst_load", Load, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", host.host_ready, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 6; v++) begin
            run($sformatf("v%0d", v), vecs[v].len, vecs[v].n,
                vecs[v].base, vecs[v].step, vecs[v].tog, vecs[v].exp);
        end

        // Reset during the second of four streamed words.
        start_load(4, 8'hC6);
        feed(4, 8'h30, 8'h01, 1'b0);
        begin
            int c = 0;
            while (ld_n - b_ld < 2 && c < 100) begin
                @(negedge clock);
                #1;
                c++;
            end
        end
        chk("abort_second_word", ld_n - b_ld, 2);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("abort_load", Load, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data_out, 0);
        chk("abort_count", ld_n - b_ld, 2);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        run("post_abort", 1, 1, 8'h7F, 8'h00, 1'b0, 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        run("sum_ok", 2, 2, 8'h10, 8'h10, 1'b0, 2);
        start_load(2, 8'h31);
        feed(2, 8'h10, 8'h10, 1'b0);
        wait_done("sum_bad");
        chk("sum_bad_err", err, 1);
        chk("sum_bad_loads", ld_n - b_ld, 0);
        chk("sum_bad_done_once", done_n - b_done, 1);
        repeat (4) @(negedge clock);
        chk("sum_bad_err_held", err, 1);
        start_load(0, 8'h00);
        chk("err_cleared_on_start", err, 0);
        wait_done("err_clear");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
